// File: rtl/unidade_controle_pkg.sv
// Shared types and decode constants for the multicycle control unit.
// Holds the FSM state encoding, instruction classes and the per-state output map.
package unidade_controle_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    CLS_LOAD,
    CLS_STORE,
    CLS_RTYPE,
    CLS_ADDI,
    CLS_ILLEGAL
  } instr_class_t;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ADDI  = 7'b0010011;

  localparam logic [2:0] F3_DWORD  = 3'b011;
  localparam logic [2:0] F3_ADD    = 3'b000;

  localparam logic [6:0] F7_ADD    = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;

  typedef struct packed {
    logic weIr;
    logic wePc;
    logic weReg;
    logic weMem;
    logic sinal;
    logic selMux1;
    logic selMux2;
    logic done;
    logic err;
  } ctrl_out_t;

  // Outputs of the state being entered; ALU/mux selects are held across EXEC..final state.
  function automatic ctrl_out_t stateOutputs(input state_t st, input instr_class_t cls,
                                             input logic isSub);
    ctrl_out_t o;
    logic      dataPath;
    o          = '0;
    dataPath   = (st == S_EXEC) || (st == S_MEM) || (st == S_WB);
    o.weIr     = (st == S_FETCH);
    o.wePc     = (st == S_FETCH);
    o.weReg    = (st == S_WB);
    o.weMem    = (st == S_MEM) && (cls == CLS_STORE);
    o.done     = (st == S_WB) || ((st == S_MEM) && (cls == CLS_STORE));
    o.err      = (st == S_ERROR);
    o.sinal    = dataPath && isSub && (cls == CLS_RTYPE);
    o.selMux1  = dataPath && (cls == CLS_RTYPE);
    o.selMux2  = dataPath && (cls != CLS_LOAD);
    return o;
  endfunction

endpackage

// File: rtl/unidade_controle_if.sv
// Bundle between the control unit and the datapath it steers.
// The master side is the control unit; the slave side is the datapath.
interface unidade_controle_if #(
  parameter int DATA_W = 64
) ();

  logic              run;
  logic [31:0]       ir;
  logic              we_ir;
  logic              we_pc;
  logic              we_reg;
  logic              we_mem;
  logic              sinal;
  logic              sel_mux1;
  logic              sel_mux2;
  logic [4:0]        ra;
  logic [4:0]        rb;
  logic [4:0]        rw;
  logic [DATA_W-1:0] imm;
  logic              done;
  logic              err;

  modport master (
    input  run, ir,
    output we_ir, we_pc, we_reg, we_mem, sinal, sel_mux1, sel_mux2,
    output ra, rb, rw, imm, done, err
  );

  modport slave (
    output run, ir,
    input  we_ir, we_pc, we_reg, we_mem, sinal, sel_mux1, sel_mux2,
    input  ra, rb, rw, imm, done, err
  );

endinterface

// File: rtl/unidade_controle_decodificador.sv
// Purely combinational instruction decoder: class, sub flag, immediate and register fields.
// Anything outside the supported LD/SD/ADD/SUB/ADDI subset decodes as CLS_ILLEGAL.
module decodificador
  import unidade_controle_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [31:0]       ir_i,
  output instr_class_t      cls_o,
  output logic              sub_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [4:0]        ra_o,
  output logic [4:0]        rb_o,
  output logic [4:0]        rw_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] imm12;

  assign opcode = ir_i[6:0];
  assign funct3 = ir_i[14:12];
  assign funct7 = ir_i[31:25];

  always_comb begin
    cls_o = CLS_ILLEGAL;
    sub_o = 1'b0;
    imm12 = '0;
    case (opcode)
      OPC_LOAD:
        if (funct3 == F3_DWORD) begin
          cls_o = CLS_LOAD;
          imm12 = ir_i[31:20];
        end
      OPC_STORE:
        if (funct3 == F3_DWORD) begin
          cls_o = CLS_STORE;
          imm12 = {ir_i[31:25], ir_i[11:7]};
        end
      OPC_RTYPE:
        if ((funct3 == F3_ADD) && ((funct7 == F7_ADD) || (funct7 == F7_SUB))) begin
          cls_o = CLS_RTYPE;
          sub_o = (funct7 == F7_SUB);
        end
      OPC_ADDI:
        if (funct3 == F3_ADD) begin
          cls_o = CLS_ADDI;
          imm12 = ir_i[31:20];
        end
      default: ;
    endcase
  end

  assign imm_o = {{(DATA_W-12){imm12[11]}}, imm12};
  assign ra_o  = ir_i[19:15];
  assign rb_o  = ir_i[24:20];
  assign rw_o  = ir_i[11:7];

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with registered Moore outputs.
// Outputs are computed from the next state so they line up with the state register.
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input logic                clk,
  input logic                reset,
  unidade_controle_if.master ctrl
);

  instr_class_t      cls;
  logic              isSub;
  logic [DATA_W-1:0] immW;
  logic [4:0]        raW;
  logic [4:0]        rbW;
  logic [4:0]        rwW;

  state_t            state_q;
  state_t            state_d;
  ctrl_out_t         out_q;
  ctrl_out_t         out_d;
  state_t            endState;

  decodificador #(
    .DATA_W (DATA_W)
  ) uDecodificador (
    .ir_i  (ctrl.ir),
    .cls_o (cls),
    .sub_o (isSub),
    .imm_o (immW),
    .ra_o  (raW),
    .rb_o  (rbW),
    .rw_o  (rwW)
  );

  // run is only sampled at instruction boundaries, so dropping it never aborts.
  assign endState = ctrl.run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (ctrl.run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = (cls == CLS_ILLEGAL) ? S_ERROR : S_EXEC;
      S_EXEC:   state_d = ((cls == CLS_LOAD) || (cls == CLS_STORE)) ? S_MEM : S_WB;
      S_MEM:    state_d = (cls == CLS_LOAD) ? S_WB : endState;
      S_WB:     state_d = endState;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IDLE;
    endcase
  end

  assign out_d = stateOutputs(state_d, cls, isSub);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign ctrl.we_ir    = out_q.weIr;
  assign ctrl.we_pc    = out_q.wePc;
  assign ctrl.we_reg   = out_q.weReg;
  assign ctrl.we_mem   = out_q.weMem;
  assign ctrl.sinal    = out_q.sinal;
  assign ctrl.sel_mux1 = out_q.selMux1;
  assign ctrl.sel_mux2 = out_q.selMux2;
  assign ctrl.done     = out_q.done;
  assign ctrl.err      = out_q.err;
  assign ctrl.ra       = raW;
  assign ctrl.rb       = rbW;
  assign ctrl.rw       = rwW;
  assign ctrl.imm      = immW;

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: expected per-instruction results are queued
// when an instruction is launched and popped when the DUT signals done.
module tb_unidade_controle;

  localparam int DATA_W = 64;

  typedef struct {
    int          lat;
    logic        weReg;
    logic        weMem;
    logic        sinal;
    logic        m1;
    logic        m2;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rw;
    logic [63:0] imm;
  } exp_t;

  logic   clk;
  logic   reset;
  int     total;
  int     bad;
  exp_t   sbQ[$];

  unidade_controle_if #(.DATA_W(DATA_W)) bus ();

  unidade_controle #(
    .DATA_W (DATA_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mkExp(input int lat, input logic weReg, input logic weMem,
                                 input logic sinal, input logic m1, input logic m2,
                                 input logic [4:0] ra, input logic [4:0] rb,
                                 input logic [4:0] rw, input logic [63:0] imm);
    exp_t e;
    e.lat = lat; e.weReg = weReg; e.weMem = weMem; e.sinal = sinal;
    e.m1 = m1; e.m2 = m2; e.ra = ra; e.rb = rb; e.rw = rw; e.imm = imm;
    return e;
  endfunction

  // Launches one instruction from a negedge; ir is loaded during FETCH like the real IR.
  task automatic applyStimulus(input logic [31:0] instr, input exp_t e, input bit keepRun,
                               input string tag);
    int   regPulses;
    int   memPulses;
    bit   seen;
    exp_t cur;
    regPulses = 0;
    memPulses = 0;
    seen      = 0;
    bus.run   = 1'b1;
    sbQ.push_back(e);
    for (int c = 1; c <= 12 && !seen; c++) begin
      @(negedge clk);
      if (bus.we_reg) regPulses++;
      if (bus.we_mem) memPulses++;
      if (c == 1) begin
        checkOutput({tag, ".fetchEn"}, {62'd0, bus.we_ir, bus.we_pc}, 64'd3);
        checkOutput({tag, ".fetchOther"}, {62'd0, bus.we_reg, bus.we_mem}, 64'd0);
        bus.ir = instr;
      end
      if (c == 2) checkOutput({tag, ".fetchOnce"}, {62'd0, bus.we_ir, bus.we_pc}, 64'd0);
      if (c == 3 && !keepRun) bus.run = 1'b0;
      if (c >= 3 && sbQ.size() > 0)
        checkOutput({tag, ".muxHold"}, {61'd0, bus.sinal, bus.sel_mux1, bus.sel_mux2},
                    {61'd0, sbQ[0].sinal, sbQ[0].m1, sbQ[0].m2});
      if (bus.done) begin
        seen = 1;
        if (sbQ.size() == 0) begin
          checkOutput({tag, ".unexpectedDone"}, 64'd1, 64'd0);
        end else begin
          cur = sbQ.pop_front();
          checkOutput({tag, ".latency"}, 64'(c), 64'(cur.lat));
          checkOutput({tag, ".weReg"}, {63'd0, bus.we_reg}, {63'd0, cur.weReg});
          checkOutput({tag, ".weMem"}, {63'd0, bus.we_mem}, {63'd0, cur.weMem});
          checkOutput({tag, ".regPulses"}, 64'(regPulses), 64'(cur.weReg));
          checkOutput({tag, ".memPulses"}, 64'(memPulses), 64'(cur.weMem));
          checkOutput({tag, ".ra"}, {59'd0, bus.ra}, {59'd0, cur.ra});
          checkOutput({tag, ".rb"}, {59'd0, bus.rb}, {59'd0, cur.rb});
          checkOutput({tag, ".rw"}, {59'd0, bus.rw}, {59'd0, cur.rw});
          checkOutput({tag, ".imm"}, bus.imm, cur.imm);
        end
      end
    end
    if (!seen) begin
      checkOutput({tag, ".doneTimeout"}, 64'd0, 64'd1);
      if (sbQ.size() > 0) void'(sbQ.pop_front());
    end
    if (!keepRun) begin
      @(negedge clk);
      checkOutput({tag, ".idleAfter"}, {62'd0, bus.we_ir, bus.done}, 64'd0);
    end
  endtask

  task automatic resetChecks(input string tag);
    checkOutput({tag, ".resetOuts"},
                {55'd0, bus.we_ir, bus.we_pc, bus.we_reg, bus.we_mem, bus.done, bus.err,
                 bus.sinal, bus.sel_mux1, bus.sel_mux2}, 64'd0);
  endtask

  task automatic errorCase(input logic [31:0] instr, input string tag);
    bus.run = 1'b1;
    @(negedge clk);
    checkOutput({tag, ".fetch"}, {63'd0, bus.we_ir}, 64'd1);
    bus.ir = instr;
    @(negedge clk);
    checkOutput({tag, ".errDecode"}, {63'd0, bus.err}, 64'd0);
    @(negedge clk);
    checkOutput({tag, ".errSet"}, {63'd0, bus.err}, 64'd1);
    for (int i = 0; i < 20; i++) begin
      bus.run = i[0];
      @(negedge clk);
      checkOutput({tag, ".errHold"}, {63'd0, bus.err}, 64'd1);
      checkOutput({tag, ".errQuiet"},
                  {59'd0, bus.we_ir, bus.we_pc, bus.we_reg, bus.we_mem, bus.done}, 64'd0);
    end
    reset = 1'b1;
    #1;
    resetChecks({tag, ".clear"});
    @(negedge clk);
    bus.run = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".idleWait"}, {62'd0, bus.we_ir, bus.err}, 64'd0);
  endtask

  task automatic midResetCase();
    int regPulses;
    int irPulses;
    regPulses = 0;
    irPulses  = 0;
    bus.run   = 1'b1;
    @(negedge clk);
    bus.ir = 32'h0000_3083;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    resetChecks("midReset");
    @(negedge clk);
    resetChecks("midResetHeld");
    bus.run = 1'b0;
    reset   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.we_reg) regPulses++;
      if (bus.we_ir) irPulses++;
    end
    checkOutput("midReset.noWeReg", 64'(regPulses), 64'd0);
    checkOutput("midReset.idle", 64'(irPulses), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    bus.run = 1'b0;
    bus.ir  = 32'h0;
    repeat (2) @(negedge clk);
    resetChecks("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idleNoRun", {63'd0, bus.we_ir}, 64'd0);

    applyStimulus(32'h0000_3083, mkExp(5, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd1, 64'd0), 0, "ld");
    applyStimulus(32'h0011_01B3, mkExp(4, 1, 0, 0, 1, 1, 5'd2, 5'd1, 5'd3, 64'd0), 0, "add");
    applyStimulus(32'h4030_8233, mkExp(4, 1, 0, 1, 1, 1, 5'd1, 5'd3, 5'd4, 64'd0), 1, "sub");
    applyStimulus(32'h0062_B423, mkExp(4, 0, 1, 0, 0, 1, 5'd5, 5'd6, 5'd8, 64'd8), 0, "sd");
    applyStimulus(32'hFFF0_0393, mkExp(4, 1, 0, 0, 0, 1, 5'd0, 5'd31, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF),
                  0, "addi");

    midResetCase();
    errorCase(32'hFFFF_FFFF, "illegalOnes");
    errorCase(32'h0000_2083, "illegalLw");
    applyStimulus(32'h0000_3083, mkExp(5, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd1, 64'd0), 0, "ldAgain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
